// File: rtl/tt_um_4bit_cpu_with_fsm_core.sv
// 4-bit accumulator CPU sequenced by a five-state FSM (IDLE, FETCH, EXEC, WB, DONE).
// Latency: A/C are written on the 4th edge of an instruction, counting the IDLE edge that samples go.
// Backpressure: ena=0 freezes FSM and all data state; a held go runs exactly one instruction.
//
// Ports:
//   clk      sole clock, rising edge
//   rst_n    asynchronous reset, active HIGH despite the name
//   ena      global enable; 0 holds FSM, accumulator, carry and latches
//   ui_in    [3:0] operand B, [7:4] unused
//   uio_in   [3:0] opcode, [4] go strobe, [7:5] unused
//   uo_out   [6:0] seven-segment of accumulator (a=bit0..g=bit6), [7] carry flag
//   uio_out  constant 0x00
//   uio_oe   constant 0x00 (all uio pins are inputs)
//
// Build option: define SEG_COMMON_ANODE_EN to invert uo_out[6:0] for
// common-anode displays; uo_out[7] (carry) is never inverted.

module tt_um_4bit_cpu_with_fsm_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic       go;
    logic       latch_en, exec_en, wb_en;
    logic [3:0] op_q, b_q;
    logic [3:0] res_q, acc;
    logic       car_q, carry;
    logic [3:0] res_c;
    logic       car_c;
    logic [4:0] wide;
    logic [6:0] seg;
    logic       unused_bits;

    assign go          = uio_in[4];
    assign unused_bits = ^{ui_in[7:4], uio_in[7:5]};

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_DONE;
            S_DONE:  if (!go) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output (control strobe) logic; ena gates every strobe so a stall holds data too
    always_comb begin
        latch_en = 1'b0;
        exec_en  = 1'b0;
        wb_en    = 1'b0;
        case (state)
            S_FETCH: latch_en = ena;
            S_EXEC:  exec_en  = ena;
            S_WB:    wb_en    = ena;
            default: ;
        endcase
    end

    // ALU works only from latched opcode/operand, so pins may change after FETCH
    always_comb begin
        res_c = acc;
        car_c = carry;
        wide  = 5'd0;
        case (op_q)
            4'h1: begin res_c = b_q; car_c = 1'b0; end
            4'h2: begin
                wide  = {1'b0, acc} + {1'b0, b_q};
                res_c = wide[3:0];
                car_c = wide[4];
            end
            4'h3: begin
                // bit 4 of the 5-bit difference is the borrow (A < B)
                wide  = {1'b0, acc} - {1'b0, b_q};
                res_c = wide[3:0];
                car_c = wide[4];
            end
            4'h4: begin res_c = acc & b_q; car_c = 1'b0; end
            4'h5: begin res_c = acc | b_q; car_c = 1'b0; end
            4'h6: begin res_c = acc ^ b_q; car_c = 1'b0; end
            4'h7: begin res_c = ~acc;      car_c = 1'b0; end
            4'h8: begin res_c = {acc[2:0], 1'b0}; car_c = acc[3]; end
            4'h9: begin res_c = {1'b0, acc[3:1]}; car_c = acc[0]; end
            4'hA: begin res_c = acc + 4'd1; car_c = (acc == 4'hF); end
            4'hB: begin res_c = acc - 4'd1; car_c = (acc == 4'h0); end
            4'hC: begin res_c = 4'h0;       car_c = 1'b0; end
            default: ;  // 0 and D-F: NOP
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            op_q  <= 4'h0;
            b_q   <= 4'h0;
            res_q <= 4'h0;
            car_q <= 1'b0;
            acc   <= 4'h0;
            carry <= 1'b0;
        end else begin
            if (latch_en) begin
                op_q <= uio_in[3:0];
                b_q  <= ui_in[3:0];
            end
            if (exec_en) begin
                res_q <= res_c;
                car_q <= car_c;
            end
            if (wb_en) begin
                acc   <= res_q;
                carry <= car_q;
            end
        end
    end

    // Hex seven-segment decode, common-cathode polarity
    always_comb begin
        seg = 7'h00;
        case (acc)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

`ifdef SEG_COMMON_ANODE_EN
    assign uo_out = {carry, ~seg};
`else
    assign uo_out = {carry, seg};
`endif

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_4bit_cpu_with_fsm_core.sv
module tb_tt_um_4bit_cpu_with_fsm_core;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_vec;
    int n_bad;

    tt_um_4bit_cpu_with_fsm_core dut (
        .clk     (clk),
        .rst_n   (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [25];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // one rising edge, ending on the following falling edge (drive/sample point)
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev;

        // Expected uo_out = {carry, seg(A)}; values hand-computed in sequence.
        vecs[0]  = '{4'h1, 4'h5, 8'h6D};  // LOAD 5
        vecs[1]  = '{4'h2, 4'hC, 8'h86};  // ADD C: 17 -> A=1 C=1
        vecs[2]  = '{4'hC, 4'h0, 8'h3F};  // CLR
        vecs[3]  = '{4'h3, 4'h1, 8'hF1};  // SUB 1: A=F borrow
        vecs[4]  = '{4'hC, 4'h0, 8'h3F};  // CLR
        vecs[5]  = '{4'hB, 4'h0, 8'hF1};  // DEC wrap: A=F C=1
        vecs[6]  = '{4'hA, 4'h0, 8'hBF};  // INC from F: A=0 C=1
        vecs[7]  = '{4'h0, 4'h7, 8'hBF};  // NOP keeps A and C
        vecs[8]  = '{4'h1, 4'h9, 8'h6F};  // LOAD 9
        vecs[9]  = '{4'h8, 4'h0, 8'hDB};  // SHL: A=2 C=1
        vecs[10] = '{4'h9, 4'h0, 8'h06};  // SHR: A=1 C=0
        vecs[11] = '{4'h7, 4'h0, 8'h79};  // NOT: A=E
        vecs[12] = '{4'h4, 4'h6, 8'h7D};  // AND 6: A=6
        vecs[13] = '{4'h5, 4'h1, 8'h07};  // OR 1: A=7
        vecs[14] = '{4'h6, 4'hF, 8'h7F};  // XOR F: A=8
        vecs[15] = '{4'hD, 4'h3, 8'h7F};  // D: NOP
        vecs[16] = '{4'h3, 4'h3, 8'h6D};  // SUB 3: A=5 no borrow
        vecs[17] = '{4'h2, 4'hB, 8'hBF};  // ADD B: 16 -> A=0 C=1
        vecs[18] = '{4'hF, 4'h1, 8'hBF};  // F: NOP
        vecs[19] = '{4'h9, 4'h0, 8'h3F};  // SHR of 0: C=0
        vecs[20] = '{4'h1, 4'hA, 8'h77};  // LOAD A
        vecs[21] = '{4'h1, 4'hB, 8'h7C};  // LOAD B
        vecs[22] = '{4'h1, 4'hD, 8'h5E};  // LOAD D
        vecs[23] = '{4'h1, 4'h4, 8'h66};  // LOAD 4
        vecs[24] = '{4'h1, 4'h3, 8'h4F};  // LOAD 3

        n_vec  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset state
        #3;
        check("reset_uo_out", uo_out, 8'h3F);
        check("reset_uio_oe", uio_oe, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        step();
        rst = 1'b0;
        repeat (3) step();
        check("post_reset_idle", uo_out, 8'h3F);
        prev = 8'h3F;

        // Table-driven instructions; go sampled on edge 1, write on edge 4
        for (int i = 0; i < 25; i++) begin
            ui_in  = {4'h0, vecs[i].b};
            uio_in = {3'b000, 1'b1, vecs[i].op};
            repeat (3) step();
            check($sformatf("vec%0d_before_wb", i), uo_out, prev);
            step();
            check($sformatf("vec%0d_op%0h", i, vecs[i].op), uo_out, vecs[i].exp);
            uio_in = 8'h00;
            repeat (2) step();
            prev = vecs[i].exp;
        end

        // Held go executes exactly one INC (A=3 -> 4)
        uio_in = 8'h1A;
        repeat (4) step();
        check("held_go_first", uo_out, 8'h66);
        repeat (10) step();
        check("held_go_no_repeat", uo_out, 8'h66);
        uio_in = 8'h00;
        repeat (2) step();
        check("held_go_released", uo_out, 8'h66);

        // ena=0 for 3 cycles in EXEC delays LOAD 8 by exactly 3 cycles;
        // operand pins changed after FETCH must have no effect
        ui_in  = 8'h08;
        uio_in = 8'h11;
        repeat (2) step();
        ena   = 1'b0;
        ui_in = 8'h01;
        repeat (3) step();
        check("stall_hold", uo_out, 8'h66);
        ena = 1'b1;
        step();
        check("stall_before_wb", uo_out, 8'h66);
        step();
        check("stall_result", uo_out, 8'h7F);
        uio_in = 8'h00;
        repeat (2) step();

        // Reset pulsed during EXEC aborts the instruction
        ui_in  = 8'h02;
        uio_in = 8'h11;
        repeat (2) step();
        rst = 1'b1;
        #2;
        check("midrst_async", uo_out, 8'h3F);
        uio_in = 8'h00;
        step();
        rst = 1'b0;
        repeat (6) step();
        check("midrst_no_write", uo_out, 8'h3F);

        // go held across reset release: instruction starts on first edge
        rst    = 1'b1;
        ui_in  = 8'h02;
        uio_in = 8'h11;
        step();
        rst = 1'b0;
        repeat (3) step();
        check("rst_go_before_wb", uo_out, 8'h3F);
        step();
        check("rst_go_result", uo_out, 8'h5B);
        uio_in = 8'h00;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
